apb_fifo_slave: RTL
===================

Name: apb_fifo_slave

Overview:
- APB slave peripheral, directly downstream of the APB master; attaches to one PSELx/PRDATAx/PREADYx slot.
- Software pushes words into an internal FIFO through APB writes.
- The FIFO drains to a hardware consumer over a valid/ready stream.
- Provides control, status, a low-watermark interrupt and a sticky overflow flag.

Parameters:
DATA_W, 32, FIFO word width (1..32); PWDATA[DATA_W-1:0] is stored.
DEPTH, 8, FIFO entries; power of two, 2..128.

Ports:
PCLK  in  1  clock.
PRESET  in  1  asynchronous active-high reset.
PADDR  in  32  address; only PADDR[3:2] decoded, other bits ignored.
PWRITE  in  1  1 = write.
PENABLE  in  1  APB access phase.
PWDATA  in  32  write data.
PSEL  in  1  slave select.
PRDATA  out  32  read data.
PREADY  out  1  transfer complete.
m_data  out  DATA_W  FIFO head word.
m_valid  out  1  head valid.
m_ready  in  1  consumer accepts head.
irq  out  1  level interrupt.

Behaviour:
- Reset (PRESET, asynchronous, active-high; clock PCLK) clears all state: PRDATA=0, PREADY=0, m_valid=0, m_data=0, irq=0, CTRL=0, THRESH=0, FIFO empty, pointers=0, overflow=0.
- APB handshake (one wait state, registered PREADY), 2-state FSM IDLE/ACK:
  - IDLE: at a PCLK edge sampling PSEL&PENABLE&!PREADY, perform the register access, load PRDATA (reads), set PREADY<=1, go to ACK.
  - ACK: next edge PREADY<=0, go to IDLE.
  - Every transfer = SETUP + 2 ACCESS cycles; exactly one side effect per transfer.
  - PRDATA holds until the next read completes.
  - PSEL without PENABLE has no effect.
- Register map (offset by PADDR[3:2]):
  - 0x0 CTRL RW: [0] EN, [1] IRQ_EN, [2] FLUSH (write-1 action, reads 0).
  - 0x4 STATUS: [0] empty, [1] full, [2] overflow (sticky, write 1 to clear), [15:8] count; other bits RO 0.
  - 0x8 TXDATA WO: write pushes PWDATA[DATA_W-1:0]; reads return 0.
  - 0xC THRESH RW: [7:0] low-watermark level.
  - Unwritten/unused bits read 0.
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
  - Push on a TXDATA write completion edge.
  - Pop on any edge with m_valid&m_ready.
  - m_valid = EN & !empty, combinational; m_data = head entry, combinational from storage.
  - EN=0 stalls output without losing data; pushes are still accepted.
- Boundaries:
  - Push while full (count==DEPTH): word dropped, overflow<=1, FIFO unchanged. Full is evaluated before a same-cycle pop, so a pop in that cycle still occurs and count ends at DEPTH-1.
  - Push and pop same edge, not full: count unchanged, both pointers advance.
  - Pop only possible when m_valid=1; an empty FIFO never underflows.
  - FLUSH: pointers and count<=0 at the write completion edge; a same-edge pop is ignored; overflow unchanged.
  - Simultaneous CTRL write with EN 1->0: m_valid drops the next cycle.
- irq = IRQ_EN & (count <= THRESH[7:0]), registered (one-cycle lag behind count/CTRL/THRESH changes).
- Reset mid-transfer: PREADY forced 0, FSM to IDLE, FIFO emptied; master may be left in ACCESS (the master's own recovery).

Test Plan:
1. After reset, read STATUS at 0x10000004 (slave at PSEL0) -> PRDATA=0x00000001, PREADY high exactly 2 cycles after SETUP, for 1 cycle.
2. EN=0, write 0xA5A5_0001..0xA5A5_0008 to TXDATA, then a 9th write 0xDEAD_BEEF -> STATUS=0x00000806 (count 8, full, overflow). Set EN=1 with m_ready=1 -> m_data sequence 0xA5A5_0001..0008 on 8 consecutive cycles, 0xDEAD_BEEF never appears, STATUS=0x00000005.
3. Write 1 to STATUS bit2 -> overflow clears, STATUS=0x00000001.
4. EN=1, m_ready toggling 1/0 every cycle while 4 words are pushed back-to-back -> all 4 emerge in order with no duplicates, count never exceeds 4, final STATUS=0x00000001.
5. THRESH=2, IRQ_EN=1, EN=0: push 3 words -> irq=1 until count reaches 3, then 0. Then EN=1, m_ready=1 -> irq returns to 1 one cycle after count reaches 2.
6. 3 words queued, EN=0, write CTRL=0x5 (FLUSH+EN) -> m_valid stays 0, STATUS=0x00000001; assert PRESET during a TXDATA access -> PREADY=0 immediately, STATUS reads 0x00000001 after release.

Source files
------------

// File: rtl/apb_fifo_slave_if.sv
// APB bus bundle for the apb_fifo_slave peripheral slot.
// The master modport drives the request; the slave modport returns PRDATA/PREADY.
interface apb_fifo_slave_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB slave that lets software push words into a FIFO drained over a valid/ready stream.
// Registers: CTRL, STATUS, TXDATA and THRESH. Also provides a low-watermark irq and a sticky overflow flag.
module apb_fifo_slave #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_fifo_slave_if.slave   apb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              en, irq_en, ovf;
  logic [7:0]        thresh;

  logic              access, wr_acc, rd_acc;
  logic [1:0]        reg_sel;
  logic              empty, full, push_req, do_push, flush, pop;
  logic [7:0]        cnt8;
  logic [31:0]       rdata;
  logic              unused_apb;

  always_comb begin
    access   = (state == IDLE) && apb.PSEL && apb.PENABLE && !apb.PREADY;
    wr_acc   = access && apb.PWRITE;
    rd_acc   = access && !apb.PWRITE;
    reg_sel  = apb.PADDR[3:2];
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    push_req = wr_acc && (reg_sel == 2'd2);
    do_push  = push_req && !full;
    flush    = wr_acc && (reg_sel == 2'd0) && apb.PWDATA[2];
    m_valid  = en && !empty;
    m_data   = mem[rd_ptr];
    pop      = m_valid && m_ready;
    cnt8     = 8'(count);
    unused_apb = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA};
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: rdata = {30'h0, irq_en, en};
      2'd1: rdata = {16'h0, cnt8, 5'h0, ovf, full, empty};
      2'd2: rdata = '0;
      2'd3: rdata = {24'h0, thresh};
      default: rdata = '0;
    endcase
  end

  // Bus FSM and register file; irq samples the pre-edge count/CTRL/THRESH.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      apb.PREADY <= 1'b0;
      apb.PRDATA <= '0;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      ovf        <= 1'b0;
      thresh     <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= irq_en && (cnt8 <= thresh);
      unique case (state)
        IDLE: begin
          if (access) begin
            apb.PREADY <= 1'b1;
            state      <= ACK;
            if (rd_acc) apb.PRDATA <= rdata;
            if (wr_acc) begin
              unique case (reg_sel)
                2'd0: begin
                  en     <= apb.PWDATA[0];
                  irq_en <= apb.PWDATA[1];
                end
                2'd1: if (apb.PWDATA[2]) ovf <= 1'b0;
                2'd2: if (full) ovf <= 1'b1;
                2'd3: thresh <= apb.PWDATA[7:0];
                default: ;
              endcase
            end
          end
        end
        ACK: begin
          apb.PREADY <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Full is judged before the pop, so a dropped push can still coincide with a pop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= apb.PWDATA[DATA_W-1:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

endmodule
